pll_lock_reset_seq: RTL and testbench

//  Consumes the PLL_LOCK output of the fabric CCC/PLL and is clocked by its OUT0 fabric clock.

---
 rtl/pll_rst_pkg.sv | 12 +
 rtl/pll_lock_reset_seq_if.sv | 23 ++
 rtl/sync_ff_chain.sv | 19 +
 rtl/pll_lock_reset_seq.sv | 121 ++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 123 ++++++++++++
 5 files changed

// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: state encoding, default parameters and width helper for pll_lock_reset_seq
package pll_rst_pkg;
    typedef enum logic [1:0] {WAIT_LOCK, DEBOUNCE, STAGE, RUN} state_t;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int LOCK_FILTER_DEF = 1024;
    localparam int STAGE_GAP_DEF   = 16;
    localparam int NUM_STAGES_DEF  = 3;
    localparam int LOSS_CNT_W_DEF  = 8;
    function automatic int clog2_min1(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction
endpackage

// File: rtl/pll_lock_reset_seq_if.sv
// pll_lock_reset_seq_if: lock/reset request inputs and staged reset outputs of the sequencer
//   PLL_LOCK, EXT_RST_N        async requests into the sequencer
//   RST_N_STG, FABRIC_RESET_N  staged and global active-low resets out
//   LOCK_STABLE, LOSS_CNT      debounced lock flag and saturating lock-loss count out
interface pll_lock_reset_seq_if #(
    parameter int NUM_STAGES = 3,
    parameter int LOSS_CNT_W = 8
);
    logic                  PLL_LOCK;
    logic                  EXT_RST_N;
    logic [NUM_STAGES-1:0] RST_N_STG;
    logic                  FABRIC_RESET_N;
    logic                  LOCK_STABLE;
    logic [LOSS_CNT_W-1:0] LOSS_CNT;
    modport master (
        output PLL_LOCK, EXT_RST_N,
        input  RST_N_STG, FABRIC_RESET_N, LOCK_STABLE, LOSS_CNT
    );
    modport slave (
        input  PLL_LOCK, EXT_RST_N,
        output RST_N_STG, FABRIC_RESET_N, LOCK_STABLE, LOSS_CNT
    );
endinterface

// File: rtl/sync_ff_chain.sv
// sync_ff_chain: STAGES-deep single-bit synchronizer
//   CLK, RESETN  clock and synchronous active-low reset (flops clear to 0)
//   d_i          async input
//   q_o          synchronized output
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] s_q;
    always_ff @(posedge CLK) begin
        if (!RESETN) s_q <= '0;
        else         s_q <= {s_q[STAGES-2:0], d_i};
    end
    assign q_o = s_q[STAGES-1];
endmodule

// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: debounces PLL lock and releases reset domains in order
//   CLK     fabric clock (PLL OUT0)
//   RESETN  synchronous active-low block reset
//   bus     slave side: PLL_LOCK/EXT_RST_N in; RST_N_STG, FABRIC_RESET_N, LOCK_STABLE, LOSS_CNT out
module pll_lock_reset_seq
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int LOCK_FILTER = LOCK_FILTER_DEF,
    parameter int STAGE_GAP   = STAGE_GAP_DEF,
    parameter int NUM_STAGES  = NUM_STAGES_DEF,
    parameter int LOSS_CNT_W  = LOSS_CNT_W_DEF
) (
    input logic               CLK,
    input logic               RESETN,
    pll_lock_reset_seq_if.slave bus
);
    localparam int DW = $clog2(LOCK_FILTER);
    localparam int GW = clog2_min1(STAGE_GAP);
    localparam int KW = $clog2(NUM_STAGES + 1);

    if (SYNC_STAGES < 2 || LOCK_FILTER < 2 || STAGE_GAP < 1 || NUM_STAGES < 1 || NUM_STAGES > 8 || LOSS_CNT_W < 1) begin : g_bad_param
        $error("pll_lock_reset_seq: parameter out of range");
    end

    logic lk_s, ex_s, ok;
    sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync_lk (.CLK(CLK), .RESETN(RESETN), .d_i(bus.PLL_LOCK), .q_o(lk_s));
    sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync_ex (.CLK(CLK), .RESETN(RESETN), .d_i(bus.EXT_RST_N), .q_o(ex_s));
    assign ok = lk_s & ex_s;

    state_t                state_q, state_d;
    logic [DW-1:0]         dcnt_q, dcnt_d;
    logic [GW-1:0]         gcnt_q, gcnt_d;
    logic [KW-1:0]         k_q, k_d;
    logic [NUM_STAGES-1:0] stg_q, stg_d;
    logic                  fab_q, fab_d;
    logic                  stab_q, stab_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= WAIT_LOCK;
            dcnt_q  <= '0;
            gcnt_q  <= '0;
            k_q     <= '0;
            stg_q   <= '0;
            fab_q   <= 1'b0;
            stab_q  <= 1'b0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            gcnt_q  <= gcnt_d;
            k_q     <= k_d;
            stg_q   <= stg_d;
            fab_q   <= fab_d;
            stab_q  <= stab_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        gcnt_d  = gcnt_q;
        k_d     = k_q;
        stg_d   = stg_q;
        fab_d   = fab_q;
        stab_d  = stab_q;
        loss_d  = loss_q;
        // Abort once sequencing has begun; only a real lock loss is counted, once per event.
        if ((state_q == STAGE || state_q == RUN) && !ok) begin
            state_d = WAIT_LOCK;
            gcnt_d  = '0;
            k_d     = '0;
            stg_d   = '0;
            fab_d   = 1'b0;
            stab_d  = 1'b0;
            loss_d  = (!lk_s && loss_q != '1) ? loss_q + LOSS_CNT_W'(1) : loss_q;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_d = ok ? DEBOUNCE : WAIT_LOCK;
                    dcnt_d  = '0;
                end
                DEBOUNCE: begin
                    if (!ok) begin
                        state_d = WAIT_LOCK;
                        dcnt_d  = '0;
                    end else if (dcnt_q == DW'(LOCK_FILTER - 1)) begin
                        state_d = STAGE;
                        stab_d  = 1'b1;
                        gcnt_d  = '0;
                        k_d     = '0;
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
                STAGE: begin
                    if (gcnt_q == GW'(STAGE_GAP - 1)) begin
                        stg_d  = stg_q | (NUM_STAGES'(1) << k_q);
                        gcnt_d = '0;
                        k_d    = k_q + KW'(1);
                        if (k_q == KW'(NUM_STAGES - 1)) begin
                            state_d = RUN;
                            fab_d   = 1'b1;
                        end
                    end else begin
                        gcnt_d = gcnt_q + GW'(1);
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign bus.RST_N_STG      = stg_q;
    assign bus.FABRIC_RESET_N = fab_q;
    assign bus.LOCK_STABLE    = stab_q;
    assign bus.LOSS_CNT       = loss_q;
endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq: directed-vector bench for pll_lock_reset_seq
module tb_pll_lock_reset_seq;
    logic clk = 1'b0;
    logic resetn;
    int   e;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pll_lock_reset_seq_if #(.NUM_STAGES(3), .LOSS_CNT_W(2)) bus ();

    pll_lock_reset_seq #(
        .SYNC_STAGES(2), .LOCK_FILTER(8), .STAGE_GAP(4), .NUM_STAGES(3), .LOSS_CNT_W(2)
    ) dut (
        .CLK(clk), .RESETN(resetn), .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic run_to(input int n);
        while (e < n) tick();
    endtask

    task automatic check_all(input string tag, input logic [2:0] stg, input logic fab, input logic stab, input logic [1:0] loss);
        check({tag, ".stg"},  32'(bus.RST_N_STG), 32'(stg));
        check({tag, ".fab"},  32'(bus.FABRIC_RESET_N), 32'(fab));
        check({tag, ".stab"}, 32'(bus.LOCK_STABLE), 32'(stab));
        check({tag, ".loss"}, 32'(bus.LOSS_CNT), 32'(loss));
    endtask

    // Lock rises just before edge 1: stable at 11, stages at 15/19/23.
    task automatic relock_full(input logic [1:0] loss);
        bus.PLL_LOCK = 1'b1;
        e = 0;
        run_to(10); check("relock.e10", 32'(bus.LOCK_STABLE), 32'd0);
        run_to(11); check_all("relock.e11", 3'b000, 1'b0, 1'b1, loss);
        run_to(14); check("relock.e14", 32'(bus.RST_N_STG), 32'b000);
        run_to(15); check("relock.e15", 32'(bus.RST_N_STG), 32'b001);
        run_to(19); check("relock.e19", 32'(bus.RST_N_STG), 32'b011);
        run_to(22); check_all("relock.e22", 3'b011, 1'b0, 1'b1, loss);
        run_to(23); check_all("relock.e23", 3'b111, 1'b1, 1'b1, loss);
    endtask

    task automatic lose(input logic [1:0] loss);
        bus.PLL_LOCK = 1'b0;
        e = 0;
        run_to(3);
        check_all("lose", 3'b000, 1'b0, 1'b0, loss);
    endtask

    initial begin
        resetn        = 1'b0;
        bus.PLL_LOCK  = 1'b1;
        bus.EXT_RST_N = 1'b1;
        e = 0;
        tick(); tick();
        check_all("reset", 3'b000, 1'b0, 1'b0, 2'd0);
        bus.PLL_LOCK = 1'b0;
        tick();
        resetn = 1'b1;
        // clean lock, then loss in RUN and relock
        relock_full(2'd0);
        lose(2'd1);
        relock_full(2'd1);
        // one-cycle external reset in RUN: aborts, not counted
        bus.EXT_RST_N = 1'b0;
        e = 0;
        tick();
        bus.EXT_RST_N = 1'b1;
        run_to(2); check("ext.e2", 32'(bus.RST_N_STG), 32'b111);
        run_to(3); check_all("ext.e3", 3'b000, 1'b0, 1'b0, 2'd1);
        run_to(23); check("ext.e23", 32'(bus.FABRIC_RESET_N), 32'd0);
        run_to(24); check_all("ext.e24", 3'b111, 1'b1, 1'b1, 2'd1);
        // coincident lock loss and external reset: counted once
        bus.PLL_LOCK  = 1'b0;
        bus.EXT_RST_N = 1'b0;
        e = 0;
        run_to(3); check_all("both", 3'b000, 1'b0, 1'b0, 2'd2);
        bus.PLL_LOCK  = 1'b1;
        bus.EXT_RST_N = 1'b1;
        e = 0;
        run_to(20); check_all("midstg", 3'b011, 1'b0, 1'b1, 2'd2);
        resetn = 1'b0;
        tick();
        check_all("midrst", 3'b000, 1'b0, 1'b0, 2'd0);
        // debounce glitch: lock low only at edge 7
        resetn = 1'b1;
        e = 0;
        run_to(6);
        bus.PLL_LOCK = 1'b0;
        tick();
        bus.PLL_LOCK = 1'b1;
        run_to(11); check("glitch.e11", 32'(bus.LOCK_STABLE), 32'd0);
        run_to(17); check("glitch.e17", 32'(bus.LOCK_STABLE), 32'd0);
        run_to(18); check_all("glitch.e18", 3'b000, 1'b0, 1'b1, 2'd0);
        run_to(22); check("glitch.e22", 32'(bus.RST_N_STG), 32'b001);
        // saturation: first loss during STAGE, five losses total
        lose(2'd1);
        relock_full(2'd1);
        lose(2'd2);
        relock_full(2'd2);
        lose(2'd3);
        relock_full(2'd3);
        lose(2'd3);
        relock_full(2'd3);
        lose(2'd3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
